// File: rtl/data_mem_responder.sv
// Responder end of the data-memory load/store handshake: one load or store
// per four-phase req/ack exchange, served from an internal RAM or from the
// switch/LED I/O locations, with a programmable wait-state delay.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  SW_ADDR     = 8'hFE,
  parameter logic [7:0]  LED_ADDR    = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       err,
  input  logic [7:0] sw_in,
  output logic [7:0] led_out,
  output logic       busy
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        capture;
  logic        commit;

  logic [7:0]  ram_q [DEPTH];
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  led_q, led_d;

  logic        is_ram, is_sw, is_led;
  logic [7:0]  ram_rd;

  // State register and wait counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; capture on request in IDLE, commit on RESP entry.
  // Every request passes through WAIT with the counter loaded to the full
  // wait count (WAIT_CYCLES = 0 spends one cycle there), so ack appears
  // WAIT_CYCLES+1 edges after the capture edge for every setting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the transaction fields when a request is accepted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Address decode on the latched address.
  always_comb begin
    is_ram = ({1'b0, addr_q} < DEPTH_W);
    is_sw  = (addr_q == SW_ADDR);
    is_led = (addr_q == LED_ADDR);
    ram_rd = ram_q[addr_q[AW-1:0]];
  end

  // RAM array: cleared on reset, written once at commit of a RAM store.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else if (commit && we_q && is_ram) begin
      ram_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  // Response data, error flag and LED register updates at commit.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    led_d   = led_q;
    if (commit) begin
      err_d = !(is_ram || is_sw || is_led);
      if (we_q) begin
        if (is_led) led_d = wdata_q;
      end else if (is_ram) begin
        rdata_d = ram_rd;
      end else if (is_sw) begin
        rdata_d = sw_in;
      end else if (is_led) begin
        rdata_d = led_q;
      end else begin
        rdata_d = '0;
      end
    end
  end

  // Response/LED registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  // Outputs derived from state and registers.
  always_comb begin
    ack     = (state_q == S_RESP);
    busy    = (state_q != S_IDLE);
    rdata   = rdata_q;
    err     = err_q;
    led_out = led_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (wait count 2 and 0) checked
// every cycle against a transaction-level model plus literal spot checks.
module tb_data_mem_responder;

  logic       clk;
  logic       reset;
  logic       req_a, req_b;
  logic       we;
  logic [7:0] addr, wdata, sw_in;
  logic       ack_a, ack_b, err_a, err_b, busy_a, busy_b;
  logic [7:0] rdata_a, rdata_b, led_a, led_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Model state per instance (0: WAIT_CYCLES=2, 1: WAIT_CYCLES=0).
  logic [7:0] m_mem [2][64];
  logic [7:0] m_led [2];
  logic [7:0] m_rdata [2];
  logic       m_err [2];
  logic       m_ack [2];
  logic       m_busy [2];

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .SW_ADDR(8'hFE), .LED_ADDR(8'hFF)) dut_a (
    .clock(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_a), .rdata(rdata_a), .err(err_a), .sw_in(sw_in), .led_out(led_a), .busy(busy_a)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .SW_ADDR(8'hFE), .LED_ADDR(8'hFF)) dut_b (
    .clock(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_b), .rdata(rdata_b), .err(err_b), .sw_in(sw_in), .led_out(led_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("A.ack",   {7'b0, ack_a},  {7'b0, m_ack[0]});
      chk("A.busy",  {7'b0, busy_a}, {7'b0, m_busy[0]});
      chk("A.rdata", rdata_a,        m_rdata[0]);
      chk("A.err",   {7'b0, err_a},  {7'b0, m_err[0]});
      chk("A.led",   led_a,          m_led[0]);
      chk("B.ack",   {7'b0, ack_b},  {7'b0, m_ack[1]});
      chk("B.busy",  {7'b0, busy_b}, {7'b0, m_busy[1]});
      chk("B.rdata", rdata_b,        m_rdata[1]);
      chk("B.err",   {7'b0, err_b},  {7'b0, m_err[1]});
      chk("B.led",   led_b,          m_led[1]);
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) m_mem[d][i] = 8'h00;
      m_led[d] = 8'h00; m_rdata[d] = 8'h00; m_err[d] = 1'b0;
      m_ack[d] = 1'b0;  m_busy[d] = 1'b0;
    end
  endtask

  // Effect of one transaction on the memory map.
  task automatic model_commit(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd);
    if (a < 8'd64) begin
      if (w) m_mem[d][a[5:0]] = wd; else m_rdata[d] = m_mem[d][a[5:0]];
      m_err[d] = 1'b0;
    end else if (a == 8'hFE) begin
      if (!w) m_rdata[d] = sw_in;
      m_err[d] = 1'b0;
    end else if (a == 8'hFF) begin
      if (w) m_led[d] = wd; else m_rdata[d] = m_led[d];
      m_err[d] = 1'b0;
    end else begin
      if (!w) m_rdata[d] = 8'h00;
      m_err[d] = 1'b1;
    end
  endtask

  task automatic set_req(input int d, input logic v);
    if (d == 0) req_a = v; else req_b = v;
  endtask

  // One handshake; entered and left just after a rising edge. Ack is
  // expected WAIT_CYCLES+1 edges after the capture edge; the bus fields are
  // scrambled right after capture to prove they are latched.
  task automatic txn(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd, input int hold);
    int wc;
    wc = (d == 0) ? 2 : 0;
    we = w; addr = a; wdata = wd;
    set_req(d, 1'b1);
    @(posedge clk); #1;
    m_busy[d] = 1'b1;
    we = ~w; addr = a ^ 8'h3C; wdata = ~wd;
    repeat (wc) @(posedge clk);
    @(posedge clk); #1;
    m_ack[d] = 1'b1;
    model_commit(d, w, a, wd);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    set_req(d, 1'b0);
    @(posedge clk); #1;
    m_ack[d] = 1'b0;
    m_busy[d] = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; addr = 8'h00; wdata = 8'h00; sw_in = 8'h00;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1;
    @(posedge clk); #1;

    // 1: basic store/load with two wait states
    txn(0, 1'b1, 8'h03, 8'h5A, 0);
    txn(0, 1'b0, 8'h03, 8'h00, 0);
    chk("T1.rdata_lit", rdata_a, 8'h5A);
    chk("T1.err_lit", {7'b0, err_a}, 8'h00);

    // 2: LED and switch locations
    txn(0, 1'b1, 8'hFF, 8'hC3, 0);
    chk("T2.led_lit", led_a, 8'hC3);
    txn(0, 1'b0, 8'hFF, 8'h00, 0);
    chk("T2.ledrd_lit", rdata_a, 8'hC3);
    sw_in = 8'h81;
    txn(0, 1'b0, 8'hFE, 8'h00, 0);
    chk("T2.sw_lit", rdata_a, 8'h81);
    txn(0, 1'b1, 8'hFE, 8'h22, 1);
    chk("T2.swst_err_lit", {7'b0, err_a}, 8'h00);
    chk("T2.swst_rdata_lit", rdata_a, 8'h81);

    // 3: decode errors and full RAM read-back
    txn(0, 1'b0, 8'h80, 8'h00, 0);
    chk("T3.bad_rdata_lit", rdata_a, 8'h00);
    chk("T3.bad_err_lit", {7'b0, err_a}, 8'h01);
    txn(0, 1'b1, 8'h40, 8'h11, 0);
    chk("T3.st_err_lit", {7'b0, err_a}, 8'h01);
    for (int i = 0; i < 64; i++) txn(0, 1'b0, 8'(i), 8'h00, 0);
    chk("T3.last_word_lit", rdata_a, 8'h00);

    // 4: req held after ack; wdata changed during WAIT
    txn(0, 1'b1, 8'h07, 8'hA5, 5);
    txn(0, 1'b0, 8'h07, 8'h00, 0);
    chk("T4.rdata_lit", rdata_a, 8'hA5);

    // 5: reset during WAIT of a store aborts it
    we = 1'b1; addr = 8'h05; wdata = 8'h77;
    req_a = 1'b1;
    @(posedge clk); #1;
    m_busy[0] = 1'b1;
    reset = 1'b0;
    req_a = 1'b0;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    txn(0, 1'b0, 8'h05, 8'h00, 0);
    chk("T5.rdata_lit", rdata_a, 8'h00);
    chk("T5.led_lit", led_a, 8'h00);

    // 6: zero wait states, back-to-back store/load pairs
    for (int i = 0; i < 10; i++) begin
      txn(1, 1'b1, 8'(i), 8'(i * 7 + 3), 0);
      txn(1, 1'b0, 8'(i), 8'h00, 0);
    end
    chk("T6.last_lit", rdata_b, 8'h42);

    @(posedge clk); #1;
    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
